// File: rtl/fp_vector_checker_pkg.sv
// rtl/fp_vector_checker_pkg.sv - shared types and field map for the FPU vector checker
package fp_wire;

  // Test vector layout (156 bits)
  localparam int VEC_W      = 156;
  localparam int VEC_D1_HI  = 155;
  localparam int VEC_D1_LO  = 124;
  localparam int VEC_D2_HI  = 123;
  localparam int VEC_D2_LO  = 92;
  localparam int VEC_D3_HI  = 91;
  localparam int VEC_D3_LO  = 60;
  localparam int VEC_RES_HI = 59;
  localparam int VEC_RES_LO = 28;
  localparam int VEC_FLG_HI = 24;
  localparam int VEC_FLG_LO = 20;
  localparam int VEC_RM_HI  = 18;
  localparam int VEC_RM_LO  = 16;
  localparam int VEC_OP_HI  = 13;
  localparam int VEC_OP_LO  = 12;
  localparam int VEC_OPC_HI = 9;
  localparam int VEC_OPC_LO = 0;

  // Canonical quiet NaN produced by the unit for invalid operations
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } fp_vec_state_type;

  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmadd;
    logic       fnmsub;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_exe_in_type;

endpackage

// File: rtl/fp_vector_checker_compare.sv
// rtl/fp_vector_checker_compare.sv - result/flag comparator with quiet-NaN tolerance
module fp_vec_compare
  import fp_wire::*;
(
  input  logic [31:0] exp_i,
  input  logic [4:0]  exp_flags_i,
  input  logic [31:0] calc_i,
  input  logic [4:0]  calc_flags_i,
  input  logic [9:0]  opcode_i,
  output logic        pass_o
);

  logic [31:0] result_diff;
  logic        unused_opcode;

  // Only opcode[9] (float-to-int) decides whether a NaN result is a real NaN
  assign unused_opcode = ^opcode_i[8:0];

  // For float results a canonical NaN matches any NaN: only exponent and quiet bit are compared
  always_comb begin
    result_diff = calc_i ^ exp_i;
    if (!opcode_i[9] && (calc_i == FP_CANON_NAN)) begin
      result_diff = {1'b0, calc_i[30:22] ^ exp_i[30:22], 22'h0};
    end
    pass_o = (result_diff == 32'h0) && (calc_flags_i == exp_flags_i);
  end

endmodule

// File: rtl/fp_vector_checker.sv
// rtl/fp_vector_checker.sv - vector sequencer/scoreboard that drives fp_unit and checks its results
module fp_vector_checker
  import fp_wire::*;
#(
  parameter int TIMEOUT      = 256,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec_data,
  input  logic             vec_last,
  output logic             vec_ready,
  output fp_exe_in_type    exe_i,
  input  logic [31:0]      exe_result,
  input  logic [4:0]       exe_flags,
  input  logic             exe_ready,
  output logic             done,
  output logic             fail,
  output logic             timeout,
  output logic [31:0]      vec_count,
  output logic [15:0]      err_count,
  output logic [VEC_W-1:0] err_vector,
  output logic [31:0]      err_result,
  output logic [4:0]       err_flags
);

  localparam int            CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  fp_vec_state_type state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             last_q, last_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [31:0]      calc_q, calc_d;
  logic [4:0]       calc_flags_q, calc_flags_d;
  logic             vec_to_q, vec_to_d;
  logic             timeout_q, timeout_d;
  logic             fail_q, fail_d;
  logic [31:0]      vec_count_q, vec_count_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [VEC_W-1:0] err_vector_q, err_vector_d;
  logic [31:0]      err_result_q, err_result_d;
  logic [4:0]       err_flags_q, err_flags_d;

  logic             cmp_pass;
  logic             vec_fail;
  logic [9:0]       opcode;

  assign opcode = vec_q[VEC_OPC_HI:VEC_OPC_LO];

  fp_vec_compare u_compare (
    .exp_i        (vec_q[VEC_RES_HI:VEC_RES_LO]),
    .exp_flags_i  (vec_q[VEC_FLG_HI:VEC_FLG_LO]),
    .calc_i       (calc_q),
    .calc_flags_i (calc_flags_q),
    .opcode_i     (opcode),
    .pass_o       (cmp_pass)
  );

  // Sequencer: accept one vector, issue it, wait for the unit, score it
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    last_d       = last_q;
    wait_cnt_d   = wait_cnt_q;
    calc_d       = calc_q;
    calc_flags_d = calc_flags_q;
    vec_to_d     = vec_to_q;
    timeout_d    = timeout_q;
    fail_d       = fail_q;
    vec_count_d  = vec_count_q;
    err_count_d  = err_count_q;
    err_vector_d = err_vector_q;
    err_result_d = err_result_q;
    err_flags_d  = err_flags_q;
    vec_fail     = vec_to_q || !cmp_pass;

    unique case (state_q)
      IDLE: begin
        if (vec_valid) begin
          vec_d   = vec_data;
          last_d  = vec_last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d   = '0;
        calc_d       = '0;
        calc_flags_d = '0;
        vec_to_d     = 1'b0;
        state_d      = WAIT;
      end
      WAIT: begin
        // A response arriving on the final wait cycle still counts
        if (exe_ready) begin
          calc_d       = exe_result;
          calc_flags_d = exe_flags;
          state_d      = CHECK;
        end else if (wait_cnt_q == WAIT_LAST) begin
          vec_to_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      CHECK: begin
        vec_count_d = vec_count_q + 32'd1;
        if (vec_fail) begin
          fail_d = 1'b1;
          if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end
          if (!fail_q) begin
            err_vector_d = vec_q;
            err_result_d = calc_q;
            err_flags_d  = calc_flags_q;
          end
        end
        if (last_q || (vec_fail && STOP_ON_FAIL)) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and scoreboard registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      last_q       <= 1'b0;
      wait_cnt_q   <= '0;
      calc_q       <= '0;
      calc_flags_q <= '0;
      vec_to_q     <= 1'b0;
      timeout_q    <= 1'b0;
      fail_q       <= 1'b0;
      vec_count_q  <= '0;
      err_count_q  <= '0;
      err_vector_q <= '0;
      err_result_q <= '0;
      err_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      last_q       <= last_d;
      wait_cnt_q   <= wait_cnt_d;
      calc_q       <= calc_d;
      calc_flags_q <= calc_flags_d;
      vec_to_q     <= vec_to_d;
      timeout_q    <= timeout_d;
      fail_q       <= fail_d;
      vec_count_q  <= vec_count_d;
      err_count_q  <= err_count_d;
      err_vector_q <= err_vector_d;
      err_result_q <= err_result_d;
      err_flags_q  <= err_flags_d;
    end
  end

  // Operands come straight from the held vector so they stay stable until the next accept
  always_comb begin
    exe_i             = '0;
    exe_i.data1       = vec_q[VEC_D1_HI:VEC_D1_LO];
    exe_i.data2       = vec_q[VEC_D2_HI:VEC_D2_LO];
    exe_i.data3       = vec_q[VEC_D3_HI:VEC_D3_LO];
    exe_i.rm          = vec_q[VEC_RM_HI:VEC_RM_LO];
    exe_i.op.fcvt_op  = vec_q[VEC_OP_HI:VEC_OP_LO];
    exe_i.op.fmadd    = opcode[0];
    exe_i.op.fadd     = opcode[1];
    exe_i.op.fsub     = opcode[2];
    exe_i.op.fmul     = opcode[3];
    exe_i.op.fdiv     = opcode[4];
    exe_i.op.fsqrt    = opcode[5];
    exe_i.op.fcmp     = opcode[6];
    exe_i.op.fcvt_i2f = opcode[8];
    exe_i.op.fcvt_f2i = opcode[9];
    exe_i.enable      = (state_q == ISSUE);
  end

  // vec_ready is held low while reset is asserted
  assign vec_ready  = reset && (state_q == IDLE);
  assign done       = (state_q == DONE);
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign vec_count  = vec_count_q;
  assign err_count  = err_count_q;
  assign err_vector = err_vector_q;
  assign err_result = err_result_q;
  assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_fp_vector_checker.sv
// tb/tb_fp_vector_checker.sv - directed self-checking bench for fp_vector_checker
module tb_fp_vector_checker;
  import fp_wire::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         vec_valid;
  logic [155:0] vec_data;
  logic         vec_last;
  logic [31:0]  exe_result;
  logic [4:0]   exe_flags;
  logic         exe_ready;

  logic          a_vec_ready, a_done, a_fail, a_timeout;
  fp_exe_in_type a_exe;
  logic [31:0]   a_vec_count, a_err_result;
  logic [15:0]   a_err_count;
  logic [155:0]  a_err_vector;
  logic [4:0]    a_err_flags;

  logic          b_vec_ready, b_done, b_fail, b_timeout;
  fp_exe_in_type b_exe;
  logic [31:0]   b_vec_count, b_err_result;
  logic [15:0]   b_err_count;
  logic [155:0]  b_err_vector;
  logic [4:0]    b_err_flags;

  int n_checks = 0;
  int miscompares = 0;
  int en_a = 0;

  always #5 clock = ~clock;

  always @(negedge clock) if (a_exe.enable) en_a <= en_a + 1;

  fp_vector_checker #(.TIMEOUT(64), .STOP_ON_FAIL(1'b1)) dut (
    .clock(clock), .reset(reset), .vec_valid(vec_valid), .vec_data(vec_data), .vec_last(vec_last),
    .vec_ready(a_vec_ready), .exe_i(a_exe), .exe_result(exe_result), .exe_flags(exe_flags),
    .exe_ready(exe_ready), .done(a_done), .fail(a_fail), .timeout(a_timeout), .vec_count(a_vec_count),
    .err_count(a_err_count), .err_vector(a_err_vector), .err_result(a_err_result), .err_flags(a_err_flags)
  );

  fp_vector_checker #(.TIMEOUT(16), .STOP_ON_FAIL(1'b0)) dut_t (
    .clock(clock), .reset(reset), .vec_valid(vec_valid), .vec_data(vec_data), .vec_last(vec_last),
    .vec_ready(b_vec_ready), .exe_i(b_exe), .exe_result(exe_result), .exe_flags(exe_flags),
    .exe_ready(exe_ready), .done(b_done), .fail(b_fail), .timeout(b_timeout), .vec_count(b_vec_count),
    .err_count(b_err_count), .err_vector(b_err_vector), .err_result(b_err_result), .err_flags(b_err_flags)
  );

  function automatic logic [155:0] mkvec(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                                         input logic [31:0] res, input logic [4:0] flg, input logic [2:0] rm,
                                         input logic [1:0] op, input logic [9:0] opc);
    return {d1, d2, d3, res, 3'b000, flg, 1'b0, rm, 2'b00, op, 2'b00, opc};
  endfunction

  function automatic logic rdy(input int w);
    return (w == 0) ? a_vec_ready : b_vec_ready;
  endfunction

  function automatic logic en(input int w);
    return (w == 0) ? a_exe.enable : b_exe.enable;
  endfunction

  task automatic do_reset();
    reset = 1'b0; vec_valid = 1'b0; vec_data = '0; vec_last = 1'b0;
    exe_ready = 1'b0; exe_result = '0; exe_flags = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Present a vector once the chosen checker is ready; returns on the negedge of its ISSUE cycle
  task automatic send_vec(input int w, input logic [155:0] v, input logic last);
    bit sent = 1'b0;
    for (int i = 0; i < 80 && !sent; i++) begin
      if (rdy(w)) begin
        vec_valid = 1'b1; vec_data = v; vec_last = last;
        @(negedge clock);
        vec_valid = 1'b0; vec_last = 1'b0;
        sent = 1'b1;
      end else begin
        @(negedge clock);
      end
    end
    if (!sent) begin
      n_checks++; miscompares++;
      $display("FAIL send_vec_accept got no vec_ready want accept within 80 cycles");
    end
  endtask

  // Model of fp_unit: answer `lat` cycles after the enable pulse, counting vec_ready seen while waiting
  task automatic unit_respond(input int w, input logic [31:0] res, input logic [4:0] flg, input int lat,
                              output fp_exe_in_type seen, output int rdy_in_wait);
    seen = '0; rdy_in_wait = 0;
    for (int i = 0; i < 80 && !en(w); i++) @(negedge clock);
    if (!en(w)) begin
      n_checks++; miscompares++;
      $display("FAIL unit_enable got no enable pulse want one within 80 cycles");
    end else begin
      seen = (w == 0) ? a_exe : b_exe;
      for (int i = 1; i <= lat; i++) begin
        @(negedge clock);
        if (rdy(w)) rdy_in_wait++;
      end
      exe_ready = 1'b1; exe_result = res; exe_flags = flg;
      @(negedge clock);
      exe_ready = 1'b0; exe_result = '0; exe_flags = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; vec_valid = 1'b1; vec_data = '1; vec_last = 1'b1;
    exe_ready = 1'b1; exe_result = '1; exe_flags = '1;
    repeat (3) @(negedge clock);
    n_checks++; if (a_vec_ready !== 1'b0) begin miscompares++; $display("FAIL rst_vec_ready got %b want 0", a_vec_ready); end
    n_checks++; if (a_exe !== '0) begin miscompares++; $display("FAIL rst_exe got %h want 0", a_exe); end
    n_checks++; if ({a_done, a_fail, a_timeout} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", {a_done, a_fail, a_timeout}); end
    n_checks++; if ({a_vec_count, a_err_count, a_err_result, a_err_flags} !== '0) begin miscompares++; $display("FAIL rst_counts got %h/%h/%h/%h want 0", a_vec_count, a_err_count, a_err_result, a_err_flags); end
    n_checks++; if (a_err_vector !== '0) begin miscompares++; $display("FAIL rst_err_vector got %h want 0", a_err_vector); end
    vec_valid = 1'b0; vec_last = 1'b0; exe_ready = 1'b0; exe_result = '0; exe_flags = '0;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (a_vec_ready !== 1'b1) begin miscompares++; $display("FAIL rst_idle_ready got %b want 1", a_vec_ready); end
  endtask

  task automatic test_single_fadd();
    fp_exe_in_type seen, e;
    int r;
    logic [155:0] v;
    do_reset();
    v = mkvec(32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 5'b0, 3'b010, 2'b00, 10'h002);
    send_vec(0, v, 1'b1);
    unit_respond(0, 32'h40000000, 5'b0, 1, seen, r);
    @(negedge clock);
    e = '0; e.data1 = 32'h3F800000; e.data2 = 32'h3F800000; e.rm = 3'b010; e.op.fadd = 1'b1; e.enable = 1'b1;
    n_checks++; if (seen !== e) begin miscompares++; $display("FAIL fadd_issue got %h want %h", seen, e); end
    n_checks++; if ({a_done, a_fail, a_timeout} !== 3'b100) begin miscompares++; $display("FAIL fadd_status got %b want 100", {a_done, a_fail, a_timeout}); end
    n_checks++; if (a_vec_count !== 32'd1 || a_err_count !== 16'd0) begin miscompares++; $display("FAIL fadd_counts got %0d/%0d want 1/0", a_vec_count, a_err_count); end
    n_checks++; if (a_vec_ready !== 1'b0) begin miscompares++; $display("FAIL fadd_done_ready got %b want 0", a_vec_ready); end
  endtask

  task automatic test_nan_rule();
    fp_exe_in_type seen;
    int r;
    logic [155:0] va, vb;
    do_reset();
    va = mkvec(32'h7F800000, 32'hFF800000, 32'h0, 32'h7FC00001, 5'b10000, 3'b000, 2'b00, 10'h002);
    vb = mkvec(32'h7F800000, 32'h0, 32'h0, 32'h7FC00001, 5'b10000, 3'b001, 2'b00, 10'h200);
    send_vec(0, va, 1'b0);
    unit_respond(0, 32'h7FC00000, 5'b10000, 2, seen, r);
    @(negedge clock);
    n_checks++; if (a_fail !== 1'b0 || a_vec_count !== 32'd1) begin miscompares++; $display("FAIL nan_float_pass got fail=%b cnt=%0d want 0/1", a_fail, a_vec_count); end
    n_checks++; if (a_vec_ready !== 1'b1) begin miscompares++; $display("FAIL nan_back_idle got %b want 1", a_vec_ready); end
    send_vec(0, vb, 1'b1);
    unit_respond(0, 32'h7FC00000, 5'b10000, 2, seen, r);
    @(negedge clock);
    n_checks++; if ({a_done, a_fail} !== 2'b11 || a_err_count !== 16'd1 || a_vec_count !== 32'd2) begin miscompares++; $display("FAIL nan_int_fail got d=%b f=%b err=%0d cnt=%0d want 1/1/1/2", a_done, a_fail, a_err_count, a_vec_count); end
    n_checks++; if (a_err_vector !== vb || a_err_result !== 32'h7FC00000 || a_err_flags !== 5'b10000) begin miscompares++; $display("FAIL nan_capture got %h %h %b", a_err_vector, a_err_result, a_err_flags); end
    do_reset();
    va = mkvec(32'h0, 32'h0, 32'h0, 32'hFFE00000, 5'b0, 3'b000, 2'b00, 10'h004);
    vb = mkvec(32'h0, 32'h0, 32'h0, 32'h7F800000, 5'b0, 3'b000, 2'b00, 10'h004);
    send_vec(0, va, 1'b0);
    unit_respond(0, 32'h7FC00000, 5'b0, 3, seen, r);
    @(negedge clock);
    n_checks++; if (a_fail !== 1'b0) begin miscompares++; $display("FAIL nan_sign_payload got %b want 0", a_fail); end
    send_vec(0, vb, 1'b1);
    unit_respond(0, 32'h7FC00000, 5'b0, 3, seen, r);
    @(negedge clock);
    n_checks++; if (a_fail !== 1'b1 || a_err_vector !== vb) begin miscompares++; $display("FAIL nan_vs_inf got fail=%b vec=%h want 1", a_fail, a_err_vector); end
  endtask

  task automatic test_stop_on_fail();
    fp_exe_in_type seen, e;
    int r, bad_ready, en0;
    logic [155:0] v, v2;
    do_reset();
    v  = mkvec(32'h40000000, 32'h3F800000, 32'h0, 32'h0, 5'b00001, 3'b001, 2'b00, 10'h008);
    v2 = mkvec(32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 5'b0, 3'b000, 2'b00, 10'h002);
    send_vec(0, v, 1'b0);
    unit_respond(0, 32'h0, 5'b0, 3, seen, r);
    @(negedge clock);
    e = '0; e.data1 = 32'h40000000; e.data2 = 32'h3F800000; e.rm = 3'b001; e.op.fmul = 1'b1; e.enable = 1'b1;
    n_checks++; if (seen !== e) begin miscompares++; $display("FAIL stop_issue got %h want %h", seen, e); end
    n_checks++; if ({a_done, a_fail, a_timeout} !== 3'b110) begin miscompares++; $display("FAIL stop_status got %b want 110", {a_done, a_fail, a_timeout}); end
    n_checks++; if (a_err_vector !== v || a_err_result !== 32'h0 || a_err_flags !== 5'b0) begin miscompares++; $display("FAIL stop_capture got %h %h %b", a_err_vector, a_err_result, a_err_flags); end
    n_checks++; if (a_err_count !== 16'd1 || a_vec_count !== 32'd1) begin miscompares++; $display("FAIL stop_counts got %0d/%0d want 1/1", a_err_count, a_vec_count); end
    en0 = en_a; bad_ready = 0;
    vec_valid = 1'b1; vec_data = v2; vec_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (a_vec_ready) bad_ready++;
    end
    vec_valid = 1'b0; vec_last = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (bad_ready != 0 || en_a != en0) begin miscompares++; $display("FAIL stop_no_accept got ready=%0d enables=%0d want 0/0", bad_ready, en_a - en0); end
    n_checks++; if (a_vec_count !== 32'd1 || a_done !== 1'b1) begin miscompares++; $display("FAIL stop_terminal got cnt=%0d done=%b want 1/1", a_vec_count, a_done); end
  endtask

  task automatic test_timeout();
    fp_exe_in_type seen;
    int r;
    logic [155:0] v, v2;
    do_reset();
    v  = mkvec(32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 5'b0, 3'b000, 2'b00, 10'h002);
    v2 = mkvec(32'h3F800000, 32'h3F800000, 32'h1, 32'h40000000, 5'b0, 3'b000, 2'b00, 10'h002);
    send_vec(1, v, 1'b0);
    n_checks++; if (b_exe.enable !== 1'b1) begin miscompares++; $display("FAIL to_issue got %b want 1", b_exe.enable); end
    repeat (16) @(negedge clock);
    n_checks++; if (b_timeout !== 1'b0) begin miscompares++; $display("FAIL to_early got %b want 0 at edge 15", b_timeout); end
    @(negedge clock);
    n_checks++; if (b_timeout !== 1'b1) begin miscompares++; $display("FAIL to_edge16 got %b want 1", b_timeout); end
    @(negedge clock);
    n_checks++; if ({b_fail, b_done, b_vec_ready} !== 3'b101 || b_err_count !== 16'd1 || b_vec_count !== 32'd1) begin miscompares++; $display("FAIL to_check got f/d/r=%b err=%0d cnt=%0d want 101/1/1", {b_fail, b_done, b_vec_ready}, b_err_count, b_vec_count); end
    n_checks++; if (b_err_vector !== v || b_err_result !== 32'h0 || b_err_flags !== 5'b0) begin miscompares++; $display("FAIL to_capture got %h %h %b", b_err_vector, b_err_result, b_err_flags); end
    send_vec(1, v2, 1'b1);
    unit_respond(1, 32'h40000000, 5'b0, 1, seen, r);
    @(negedge clock);
    n_checks++; if ({b_done, b_fail, b_timeout} !== 3'b111 || b_vec_count !== 32'd2 || b_err_count !== 16'd1 || b_err_vector !== v) begin miscompares++; $display("FAIL to_continue got %b cnt=%0d err=%0d", {b_done, b_fail, b_timeout}, b_vec_count, b_err_count); end
    do_reset();
    send_vec(1, v, 1'b1);
    unit_respond(1, 32'h40000000, 5'b0, 16, seen, r);
    @(negedge clock);
    n_checks++; if ({b_done, b_fail, b_timeout} !== 3'b100 || b_vec_count !== 32'd1) begin miscompares++; $display("FAIL to_ready_wins got %b cnt=%0d want 100/1", {b_done, b_fail, b_timeout}, b_vec_count); end
  endtask

  task automatic test_back_to_back();
    fp_exe_in_type seen, e;
    int r1, r2, en0;
    logic [155:0] v1, v2;
    do_reset();
    en0 = en_a;
    repeat (3) @(negedge clock);
    v1 = mkvec(32'h40400000, 32'h3F800000, 32'h0, 32'h40400000, 5'b0, 3'b000, 2'b00, 10'h010);
    v2 = mkvec(32'h3F800000, 32'h40000000, 32'h0, 32'h3F000000, 5'b0, 3'b000, 2'b00, 10'h010);
    send_vec(0, v1, 1'b0);
    vec_valid = 1'b1; vec_data = v2; vec_last = 1'b1;
    unit_respond(0, 32'h40400000, 5'b0, 30, seen, r1);
    e = '0; e.data1 = 32'h40400000; e.data2 = 32'h3F800000; e.op.fdiv = 1'b1; e.enable = 1'b1;
    n_checks++; if (seen !== e) begin miscompares++; $display("FAIL b2b_issue got %h want %h", seen, e); end
    n_checks++; if (a_exe.data1 !== 32'h40400000 || a_exe.data2 !== 32'h3F800000 || a_exe.enable !== 1'b0) begin miscompares++; $display("FAIL b2b_hold got %h %h %b", a_exe.data1, a_exe.data2, a_exe.enable); end
    send_vec(0, v2, 1'b1);
    unit_respond(0, 32'h3F000000, 5'b0, 30, seen, r2);
    vec_valid = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++; if (r1 != 0 || r2 != 0) begin miscompares++; $display("FAIL b2b_ready_in_wait got %0d/%0d want 0/0", r1, r2); end
    n_checks++; if (en_a - en0 != 2) begin miscompares++; $display("FAIL b2b_enables got %0d want 2", en_a - en0); end
    n_checks++; if ({a_done, a_fail} !== 2'b10 || a_vec_count !== 32'd2) begin miscompares++; $display("FAIL b2b_status got %b cnt=%0d want 10/2", {a_done, a_fail}, a_vec_count); end
  endtask

  task automatic test_reset_in_wait();
    int en0;
    logic [155:0] v;
    do_reset();
    v = mkvec(32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 5'b0, 3'b000, 2'b00, 10'h002);
    send_vec(0, v, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    en0 = en_a;
    repeat (2) @(negedge clock);
    exe_ready = 1'b1; exe_result = 32'h40000000; exe_flags = 5'b0;
    @(negedge clock);
    exe_ready = 1'b0; exe_result = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (a_vec_count !== 32'd0 || a_err_count !== 16'd0 || a_err_result !== 32'h0) begin miscompares++; $display("FAIL rw_counts got %0d/%0d/%h want 0", a_vec_count, a_err_count, a_err_result); end
    n_checks++; if ({a_done, a_fail, a_timeout, a_vec_ready} !== 4'b0001) begin miscompares++; $display("FAIL rw_state got %b want 0001", {a_done, a_fail, a_timeout, a_vec_ready}); end
    n_checks++; if (en_a != en0) begin miscompares++; $display("FAIL rw_no_issue got %0d enables want 0", en_a - en0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish within 200000 time units");
    $fatal(1, "time limit reached");
  end

  initial begin
    test_reset();
    test_single_fadd();
    test_nan_rule();
    test_stop_on_fail();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, miscompares);
    $finish;
  end

endmodule
